delta_scan_engine: RTL and testbench

- Parametrised difference-array accumulator with a sequential scan engine; next generation of the team's 16-cell delta/min/max block.
- Accepts range-add and write commands into a signed cell array of DEPTH entries.
- On SCAN, walks the array from top index to 0, reconstructing per-bin values (delta), their first prefix (count) and second prefix (total).
- Reports lowest/highest non-zero bin, final total and an overflow flag. Sits behind the tile's instruction decoder; results feed the 8-bit output mux.

---
 rtl/delta_scan_engine_if.sv | 39 +++
 rtl/delta_scan_engine.sv | 185 ++++++++++++++++++
 tb/tb_delta_scan_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/delta_scan_engine_if.sv
// Command/result bundle for delta_scan_engine: one command channel in, one
// result record plus status flags out.
interface delta_scan_engine_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
);
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // The master holds cmd_* stable while cmd_valid is high; cmd_ready is low only
  // while a scan runs. Result fields are meaningful while res_valid is high and
  // stay put until the next accepted command.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_lo;
  logic [IDX_W-1:0]  cmd_hi;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic              res_valid;
  logic              res_found;
  logic [IDX_W-1:0]  res_min;
  logic [IDX_W-1:0]  res_max;
  logic [ACC_W-1:0]  res_sum;
  logic              res_ovf;
  logic              err;
  logic              dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_data,
    input  cmd_ready, busy, res_valid, res_found, res_min, res_max,
    input  res_sum, res_ovf, err, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_data,
    output cmd_ready, busy, res_valid, res_found, res_min, res_max,
    output res_sum, res_ovf, err, dbg_state
  );
endinterface

// File: rtl/delta_scan_engine.sv
// Difference-array accumulator: range-add/write into a signed cell array, then a
// top-down scan rebuilds delta, count and total and reports min/max hit bins.
module delta_scan_engine #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int CELL_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  delta_scan_engine_if.slave  bus
);
  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SCAN  = 2'b11;

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_busy;
  logic                      w_ready;
  logic                      w_accept;

  logic signed [CELL_W-1:0]  r_mem [DEPTH];
  logic [IDX_W-1:0]          r_k;
  logic signed [ACC_W-1:0]   r_delta;
  logic signed [ACC_W-1:0]   r_count;
  logic signed [ACC_W-1:0]   r_total;
  logic                      r_found;
  logic [IDX_W-1:0]          r_min;
  logic [IDX_W-1:0]          r_max;
  logic                      r_ovf;
  logic                      r_done;
  logic                      r_err;

  logic                      r_res_valid;
  logic                      r_res_found;
  logic [IDX_W-1:0]          r_res_min;
  logic [IDX_W-1:0]          r_res_max;
  logic [ACC_W-1:0]          r_res_sum;
  logic                      r_res_ovf;

  logic signed [CELL_W-1:0]  w_cell;
  logic signed [ACC_W-1:0]   w_cell_ext;
  logic signed [ACC_W-1:0]   w_delta_new;
  logic signed [ACC_W-1:0]   w_count_new;
  logic signed [ACC_W-1:0]   w_total_new;
  logic                      w_ovf_step;
  logic signed [CELL_W-1:0]  w_data_cell;
  logic [IDX_W-1:0]          w_lo_m1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && bus.cmd_op == OP_SCAN) w_state_nxt = ST_SCAN;
      ST_SCAN: if (r_k == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy   = (r_state == ST_SCAN);
    w_ready  = !w_busy;
    w_accept = bus.cmd_valid && w_ready;
  end

  // ---------------- scan datapath ----------------
  always_comb begin
    w_cell      = r_mem[r_k];
    w_cell_ext  = ACC_W'(w_cell);
    w_delta_new = r_delta + w_cell_ext;
    w_count_new = r_count + w_delta_new;
    w_total_new = r_total + w_count_new;
    // Signed overflow: operands agree in sign, result disagrees.
    w_ovf_step  = ((r_delta[ACC_W-1] == w_cell_ext[ACC_W-1]) &&
                   (w_delta_new[ACC_W-1] != r_delta[ACC_W-1])) ||
                  ((r_count[ACC_W-1] == w_delta_new[ACC_W-1]) &&
                   (w_count_new[ACC_W-1] != r_count[ACC_W-1])) ||
                  ((r_total[ACC_W-1] == w_count_new[ACC_W-1]) &&
                   (w_total_new[ACC_W-1] != r_total[ACC_W-1]));
    w_data_cell = CELL_W'(bus.cmd_data);
    w_lo_m1     = bus.cmd_lo - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_k         <= '0;
      r_delta     <= '0;
      r_count     <= '0;
      r_total     <= '0;
      r_found     <= 1'b0;
      r_min       <= '0;
      r_max       <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_found <= 1'b0;
      r_res_min   <= '0;
      r_res_max   <= '0;
      r_res_sum   <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;

      // Results land one edge after the last bin so the final total is settled.
      if (r_done) begin
        r_res_valid <= 1'b1;
        r_res_found <= r_found;
        r_res_min   <= r_min;
        r_res_max   <= r_max;
        r_res_sum   <= r_total;
        r_res_ovf   <= r_ovf;
      end

      if (r_state == ST_SCAN) begin
        r_delta <= w_delta_new;
        r_count <= w_count_new;
        r_total <= w_total_new;
        if (w_ovf_step) r_ovf <= 1'b1;
        // Walking downwards: the first hit is the highest bin, the last the lowest.
        if (w_delta_new != '0) begin
          r_found <= 1'b1;
          r_min   <= r_k;
          if (!r_found) r_max <= r_k;
        end
        r_k <= r_k - 1'b1;
        if (r_k == '0) r_done <= 1'b1;
      end

      if (w_accept) begin
        r_res_valid <= 1'b0;
        case (bus.cmd_op)
          OP_CLEAR: for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
          OP_WRITE: r_mem[bus.cmd_hi] <= w_data_cell;
          OP_ADD: begin
            if (bus.cmd_lo <= bus.cmd_hi) begin
              // lo-1 < hi whenever lo <= hi, so the two writes never collide.
              r_mem[bus.cmd_hi] <= r_mem[bus.cmd_hi] + w_data_cell;
              if (bus.cmd_lo != '0) r_mem[w_lo_m1] <= r_mem[w_lo_m1] - w_data_cell;
            end else begin
              r_err <= 1'b1;
            end
          end
          OP_SCAN: begin
            r_k     <= IDX_W'(DEPTH - 1);
            r_delta <= '0;
            r_count <= '0;
            r_total <= '0;
            r_found <= 1'b0;
            r_min   <= '0;
            r_max   <= '0;
            r_ovf   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.res_valid = r_res_valid;
  assign bus.res_found = r_res_found;
  assign bus.res_min   = r_res_min;
  assign bus.res_max   = r_res_max;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_ovf   = r_res_ovf;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_delta_scan_engine.sv
// Directed bench for delta_scan_engine: a 16-bit-accumulator instance and an
// 8-bit-accumulator instance, with a result scoreboard fed by the stimulus.
module tb_delta_scan_engine;
  localparam int W = 26;  // {found, min[3:0], max[3:0], sum[15:0], ovf}

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SCAN  = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   err_cycles0;
  int   err_cycles1;
  logic prev_v0;
  logic prev_v1;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  delta_scan_engine_if #(.IDX_W(4), .DATA_W(4), .ACC_W(16)) if0 ();
  delta_scan_engine_if #(.IDX_W(4), .DATA_W(4), .ACC_W(8))  if1 ();

  delta_scan_engine #(.IDX_W(4), .DATA_W(4), .CELL_W(8), .ACC_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  delta_scan_engine #(.IDX_W(4), .DATA_W(4), .CELL_W(8), .ACC_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(logic f, logic [3:0] mn, logic [3:0] mx,
                                        logic [15:0] s, logic o);
    return {f, mn, mx, s, o};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (if0.err) err_cycles0++;
    if (if1.err) err_cycles1++;
    if (if0.res_valid && !prev_v0) begin
      got = {if0.res_found, if0.res_min, if0.res_max, if0.res_sum, if0.res_ovf};
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL result0: unexpected result %0h, expected none", got);
      end else begin
        exp = exp_q0.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result0: got %0h, expected %0h", got, exp);
        end
      end
    end
    if (if1.res_valid && !prev_v1) begin
      got = {if1.res_found, if1.res_min, if1.res_max,
             {{8{if1.res_sum[7]}}, if1.res_sum}, if1.res_ovf};
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL result1: unexpected result %0h, expected none", got);
      end else begin
        exp = exp_q1.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result1: got %0h, expected %0h", got, exp);
        end
      end
    end
    prev_v0 = if0.res_valid;
    prev_v1 = if1.res_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(int sel, logic [1:0] op, logic [3:0] lo, logic [3:0] hi,
                       logic [3:0] data);
    @(negedge clk);
    if (sel == 0) begin
      if0.cmd_op = op; if0.cmd_lo = lo; if0.cmd_hi = hi; if0.cmd_data = data;
      if0.cmd_valid = 1'b1;
    end else begin
      if1.cmd_op = op; if1.cmd_lo = lo; if1.cmd_hi = hi; if1.cmd_data = data;
      if1.cmd_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if0.cmd_valid = 1'b0;
    if1.cmd_valid = 1'b0;
  endtask

  // Issues SCAN, pushes the expected record, and times busy / result latency.
  // With poke set, a WRITE is offered mid-scan and must be refused.
  task automatic scan(int sel, logic [W-1:0] exp, bit poke);
    int  n;
    int  busy_cnt;
    int  lat;
    bit  seen;
    logic b;
    logic v;
    if (sel == 0) exp_q0.push_back(exp);
    else          exp_q1.push_back(exp);
    drive(sel, OP_SCAN, 4'd0, 4'd0, 4'd0);
    n = 0; busy_cnt = 0; lat = -1; seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      b = (sel == 0) ? if0.busy : if1.busy;
      v = (sel == 0) ? if0.res_valid : if1.res_valid;
      if (poke && n == 3) begin
        if0.cmd_op = OP_WRITE; if0.cmd_hi = 4'd3; if0.cmd_lo = 4'd0;
        if0.cmd_data = 4'd9; if0.cmd_valid = 1'b1;
        check("ready_while_busy", 32'(if0.cmd_ready), 32'd0);
      end
      if (poke && n == 4) if0.cmd_valid = 1'b0;
      if (b) busy_cnt++;
      if (v) begin
        seen = 1'b1;
        lat  = n;
      end
      n++;
    end
    check("scan_completed", 32'(seen), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    check("result_latency", 32'(lat), 32'd17);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; err_cycles0 = 0; err_cycles1 = 0;
    prev_v0 = 1'b0; prev_v1 = 1'b0;
    if0.cmd_valid = 1'b0; if0.cmd_op = '0; if0.cmd_lo = '0; if0.cmd_hi = '0; if0.cmd_data = '0;
    if1.cmd_valid = 1'b0; if1.cmd_op = '0; if1.cmd_lo = '0; if1.cmd_hi = '0; if1.cmd_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_busy",      32'(if0.busy),      32'd0);
    check("rst_ready",     32'(if0.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(if0.res_valid), 32'd0);
    check("rst_result",    32'({if0.res_found, if0.res_min, if0.res_max, if0.res_sum, if0.res_ovf}), 32'd0);
    check("rst_err",       32'(if0.err),       32'd0);
    check("rst_state",     32'(if0.dbg_state), 32'd0);
    check("rst_ready1",    32'(if1.cmd_ready), 32'd1);

    // Single-bin add: delta 5 at bin 3, totals 5,10,15,20.
    drive(0, OP_ADD, 4'd3, 4'd3, 4'd5);
    scan(0, pack(1'b1, 4'd3, 4'd3, 16'd20, 1'b0), 1'b0);

    // Range add [2,5] of 3: counts 3,6,9,12,12,12.
    drive(0, OP_CLEAR, 4'd0, 4'd0, 4'd0);
    drive(0, OP_ADD, 4'd2, 4'd5, 4'd3);
    scan(0, pack(1'b1, 4'd2, 4'd5, 16'd54, 1'b0), 1'b0);

    // Empty array.
    drive(0, OP_CLEAR, 4'd0, 4'd0, 4'd0);
    scan(0, pack(1'b0, 4'd0, 4'd0, 16'd0, 1'b0), 1'b0);

    // Reversed range rejected; WRITE during busy ignored.
    drive(0, OP_ADD, 4'd3, 4'd3, 4'd5);
    drive(0, OP_ADD, 4'd7, 4'd4, 4'd1);
    @(negedge clk);
    check("err_pulse_hi", 32'(if0.err), 32'd1);
    @(negedge clk);
    check("err_pulse_lo", 32'(if0.err), 32'd0);
    scan(0, pack(1'b1, 4'd3, 4'd3, 16'd20, 1'b0), 1'b1);
    scan(0, pack(1'b1, 4'd3, 4'd3, 16'd20, 1'b0), 1'b0);

    // WRITE 2 at bin 6: delta 2 for bins 6..0, counts 2..14, total 56.
    drive(0, OP_CLEAR, 4'd0, 4'd0, 4'd0);
    drive(0, OP_WRITE, 4'd0, 4'd6, 4'd2);
    scan(0, pack(1'b1, 4'd0, 4'd6, 16'd56, 1'b0), 1'b0);

    // Range starting at 0: no lower decrement; counts 4,8, total 12.
    drive(0, OP_CLEAR, 4'd0, 4'd0, 4'd0);
    drive(0, OP_ADD, 4'd0, 4'd1, 4'd4);
    scan(0, pack(1'b1, 4'd0, 4'd1, 16'd12, 1'b0), 1'b0);

    // 8-bit accumulators: count 15*k overflows; total 2040 mod 256 = 0xF8.
    drive(1, OP_ADD, 4'd0, 4'd15, 4'd15);
    scan(1, pack(1'b1, 4'd0, 4'd15, 16'hFFF8, 1'b1), 1'b0);
    drive(1, OP_CLEAR, 4'd0, 4'd0, 4'd0);
    scan(1, pack(1'b0, 4'd0, 4'd0, 16'd0, 1'b0), 1'b0);

    // Reset during scan cycle 5 aborts and wipes the array.
    drive(0, OP_ADD, 4'd3, 4'd3, 4'd5);
    drive(0, OP_SCAN, 4'd0, 4'd0, 4'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",      32'(if0.busy),      32'd0);
    check("midrst_res_valid", 32'(if0.res_valid), 32'd0);
    check("midrst_ready",     32'(if0.cmd_ready), 32'd1);
    rst = 1'b0;
    scan(0, pack(1'b0, 4'd0, 4'd0, 16'd0, 1'b0), 1'b0);

    repeat (3) @(negedge clk);
    check("err_cycles0", 32'(err_cycles0), 32'd1);
    check("err_cycles1", 32'(err_cycles1), 32'd0);
    check("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check("queue1_drained", 32'(exp_q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
